// File: rtl/ecp_pkg.sv
// Shared secp256k1 constants, datapath widths and FSM state type for the
// serial modular multiplier family.
package ecp_pkg;

    localparam int WIDTH  = 256;
    localparam int RWIDTH = WIDTH + 2;
    localparam int CNT_W  = $clog2(WIDTH);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [WIDTH-1:0] P_ROM_CONST =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [WIDTH-1:0] GX_ROM_CONST =
        256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
    localparam logic [WIDTH-1:0] GY_ROM_CONST =
        256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Both operands must already be reduced modulo p.
    function automatic logic operands_in_range(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] p);
        return (a < p) && (b < p);
    endfunction

endpackage

// File: rtl/mod_dbl_add_step.sv
// One interleaved step: r = 2r mod p, then r = r + bit*a mod p.
// Pure combinational so it can be replicated in a word-parallel multiplier.
module mod_dbl_add_step
    import ecp_pkg::*;
(
    input  logic [RWIDTH-1:0] r,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  p,
    input  logic              b_bit,
    output logic [RWIDTH-1:0] r_next
);

    logic [RWIDTH-1:0] p_ext_s;
    logic [RWIDTH-1:0] dbl_s;
    logic [RWIDTH-1:0] dbl_red_s;
    logic [RWIDTH-1:0] sum_s;

    assign p_ext_s = {2'b00, p};

    // r < p keeps 2r and 2r-p+a below 2^257, so 258 bits never overflow.
    always_comb begin
        dbl_s = r << 1;
        if (dbl_s >= p_ext_s) begin
            dbl_red_s = dbl_s - p_ext_s;
        end else begin
            dbl_red_s = dbl_s;
        end
        if (b_bit) begin
            sum_s = dbl_red_s + {2'b00, a};
        end else begin
            sum_s = dbl_red_s;
        end
        if (sum_s >= p_ext_s) begin
            r_next = sum_s - p_ext_s;
        end else begin
            r_next = sum_s;
        end
    end

endmodule

// File: rtl/mod_mul_serial.sv
// Bit-serial MSB-first modular multiplier: result = (a_in*b_in) mod p_in in
// 256 steps. Optional operand range check enabled by MOD_MUL_OPERAND_CHECK_EN.
module mod_mul_serial
    import ecp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] p_in,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
`ifdef MOD_MUL_OPERAND_CHECK_EN
    ,
    output logic             err
`endif
);

    state_e            state_r;
    state_e            state_nxt_s;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [WIDTH-1:0]  p_r;
    logic [RWIDTH-1:0] r_r;
    logic [RWIDTH-1:0] step_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [WIDTH-1:0]  result_r;
    logic              busy_r;
    logic              done_r;
    logic              bad_s;

`ifdef MOD_MUL_OPERAND_CHECK_EN
    logic err_r;
    logic err_pend_r;

    assign bad_s = ~operands_in_range(a_in, b_in, p_in);
    assign err   = err_r;
`else
    assign bad_s = 1'b0;
`endif

    assign result = result_r;
    assign busy   = busy_r;
    assign done   = done_r;

    mod_dbl_add_step u_step (
        .r      (r_r),
        .a      (a_r),
        .p      (p_r),
        .b_bit  (b_r[cnt_r]),
        .r_next (step_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a rejected operand pair skips straight to DONE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (bad_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Operand latch, accumulator, bit counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            p_r      <= {WIDTH{1'b0}};
            r_r      <= {RWIDTH{1'b0}};
            cnt_r    <= CNT_ZERO;
            result_r <= {WIDTH{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
`ifdef MOD_MUL_OPERAND_CHECK_EN
            err_r      <= 1'b0;
            err_pend_r <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_r    <= a_in;
                        b_r    <= b_in;
                        p_r    <= p_in;
                        r_r    <= {RWIDTH{1'b0}};
                        cnt_r  <= CNT_MAX;
                        busy_r <= ~bad_s;
`ifdef MOD_MUL_OPERAND_CHECK_EN
                        err_r      <= 1'b0;
                        err_pend_r <= bad_s;
`endif
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_r <= step_s;
                    if (cnt_r == CNT_ZERO) begin
                        busy_r <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_DONE: begin
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
`ifdef MOD_MUL_OPERAND_CHECK_EN
                    err_r <= err_pend_r;
                    if (err_pend_r) begin
                        result_r <= {WIDTH{1'b0}};
                    end else begin
                        result_r <= r_r[WIDTH-1:0];
                    end
`else
                    result_r <= r_r[WIDTH-1:0];
`endif
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_mul_serial.sv
// Scoreboard bench for mod_mul_serial: stimulus pushes expected results from a
// wide-arithmetic reference; a done-triggered monitor pops and compares.
module tb_mod_mul_serial;
    import ecp_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] p_in;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;
`ifdef MOD_MUL_OPERAND_CHECK_EN
    logic             err;
`endif

    mod_mul_serial dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
        .p_in   (p_in),
        .result (result),
        .busy   (busy),
        .done   (done)
`ifdef MOD_MUL_OPERAND_CHECK_EN
        ,
        .err    (err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] res;
        int               lat;
        logic             err;
    } exp_t;

    exp_t exp_q[$];
    int   start_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   done_cnt = 0;
    logic [WIDTH-1:0] last_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [WIDTH-1:0] p);
        logic [2*WIDTH-1:0] prod;
        logic [2*WIDTH-1:0] rem;
        prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        rem  = prod % {{WIDTH{1'b0}}, p};
        return rem[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] rand256();
        logic [WIDTH-1:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: got done with empty scoreboard, required none");
            end else begin
                exp_t e;
                int   s;
                e = exp_q.pop_front();
                s = start_q.pop_front();
                check("result", result, e.res);
                check("latency", WIDTH'(cyc - s), WIDTH'(e.lat));
                check("busy_at_done", WIDTH'(busy), WIDTH'(0));
`ifdef MOD_MUL_OPERAND_CHECK_EN
                check("err_at_done", WIDTH'(err), WIDTH'(e.err));
`endif
                last_res = e.res;
            end
        end
    end

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] p, input int lat,
                         input logic exp_err, input logic exp_busy);
        exp_t e;
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        p_in  = p;
        start = 1'b1;
        e.res = exp_err ? '0 : ref_mul(a, b, p);
        e.lat = lat;
        e.err = exp_err;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start_q.push_back(cyc);
        start = 1'b0;
        a_in  = rand256();
        b_in  = rand256();
        p_in  = rand256();
        @(negedge clk);
        check("busy_after_start", WIDTH'(busy), WIDTH'(exp_busy));
    endtask

    task automatic wait_done(input int prev, input int budget);
        int k = 0;
        while (done_cnt == prev && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (done_cnt == prev) begin
            n_checks++;
            $display("FAIL done_timeout: got no done in %0d cycles, required one", budget);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run_one(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] p);
        int prev;
        prev = done_cnt;
        issue(a, b, p, 257, 1'b0, 1'b1);
        wait_done(prev, 400);
    endtask

    initial begin
        logic [WIDTH-1:0] pm1;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic [WIDTH-1:0] small_p;
        int               prev;

        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        p_in  = P_ROM_CONST;
        repeat (3) @(negedge clk);
        check("reset_result", result, '0);
        check("reset_busy", WIDTH'(busy), WIDTH'(0));
        check("reset_done", WIDTH'(done), WIDTH'(0));
`ifdef MOD_MUL_OPERAND_CHECK_EN
        check("reset_err", WIDTH'(err), WIDTH'(0));
`endif
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_one(256'd2, 256'd3, P_ROM_CONST);
        pm1 = P_ROM_CONST - 256'd1;
        run_one(pm1, pm1, P_ROM_CONST);
        run_one(GX_ROM_CONST, 256'd1, P_ROM_CONST);
        run_one(256'd0, GY_ROM_CONST, P_ROM_CONST);
        repeat (20) @(negedge clk);
        check("result_hold", result, last_res);

        // Second start mid-run must be ignored.
        prev = done_cnt;
        issue(GX_ROM_CONST, GY_ROM_CONST, P_ROM_CONST, 257, 1'b0, 1'b1);
        repeat (9) @(negedge clk);
        a_in  = 256'd11;
        b_in  = 256'd13;
        p_in  = P_ROM_CONST;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(prev, 400);
        repeat (300) @(negedge clk);
        check("single_done", WIDTH'(done_cnt - prev), WIDTH'(1));

        // Reset in the middle of RUN aborts with no done.
        prev = done_cnt;
        issue(GX_ROM_CONST, GX_ROM_CONST, P_ROM_CONST, 257, 1'b0, 1'b1);
        repeat (99) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_result", result, '0);
        check("abort_busy", WIDTH'(busy), WIDTH'(0));
        check("abort_done", WIDTH'(done), WIDTH'(0));
        exp_q.delete();
        start_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        check("no_done_after_abort", WIDTH'(done_cnt - prev), WIDTH'(0));
        run_one(256'd5, 256'd7, P_ROM_CONST);

        // Randomized operands reduced below P.
        for (int i = 0; i < 6; i++) begin
            ra = rand256();
            rb = rand256();
            if (ra >= P_ROM_CONST) ra = ra - P_ROM_CONST;
            if (rb >= P_ROM_CONST) rb = rb - P_ROM_CONST;
            run_one(ra, rb, P_ROM_CONST);
        end

        // Small non-curve modulus exercises frequent reductions.
        small_p = 256'd1000003;
        for (int i = 0; i < 2; i++) begin
            ra = WIDTH'($urandom_range(1000002, 0));
            rb = WIDTH'($urandom_range(1000002, 0));
            run_one(ra, rb, small_p);
        end

`ifdef MOD_MUL_OPERAND_CHECK_EN
        prev = done_cnt;
        issue(P_ROM_CONST, 256'd1, P_ROM_CONST, 1, 1'b1, 1'b0);
        wait_done(prev, 20);
        check("err_held", WIDTH'(err), WIDTH'(1));
        prev = done_cnt;
        issue(256'd2, 256'd3, P_ROM_CONST, 257, 1'b0, 1'b1);
        check("err_cleared_on_start", WIDTH'(err), WIDTH'(0));
        wait_done(prev, 400);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
